// File: rtl/buzzer_seq_pkg.sv
// buzzer_seq_pkg
//   Shared definitions for the buzzer pattern sequencer: register word
//   indices, CTRL/STATUS bit positions, step field layout and the FSM
//   state encoding.
package buzzer_seq_pkg;

    // Register word indices
    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_STATUS    = 4'd1;
    localparam logic [3:0] REG_STEP_BASE = 4'd8;

    // CTRL bits
    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_LOOP  = 2;

    // STATUS bits
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_IDX_LSB = 4;
    localparam int STATUS_DONE    = 8;

    // Step register layout
    localparam int TONE_W   = 2;
    localparam int DUR_W    = 8;
    localparam int TONE_LSB = 0;
    localparam int DUR_LSB  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [DUR_W-1:0]  dur;
        logic [TONE_W-1:0] tone;
    } step_t;

endpackage

// File: rtl/buzzer_seq_tick.sv
// buzzer_seq_tick
//   Duration prescaler. Counts modulo DIV while en is high and emits a
//   one-cycle tick on the last count of each period.
//   Ports:
//     clk, RST : clock, synchronous active-high reset
//     clr      : force count to 0 (restart the period)
//     en       : advance the count
//     tick     : one-cycle pulse every DIV enabled cycles
module buzzer_seq_tick #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (RST || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // A clear in the same cycle restarts the period, so no tick then.
    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/buzzer_seq.sv
// buzzer_seq
//   Pattern sequencer feeding the buzzer tone generator's mode input.
//   Software loads up to NSTEP {tone, dur} steps, then STARTs playback;
//   each step is held for dur * TICK_DIV cycles, optionally looping.
//   Ports:
//     clk, RST      : clock, synchronous active-high reset
//     we, re        : single-cycle register write / read strobes
//     addr, wdata   : register word index and write data
//     rdata         : registered read data (valid the cycle after re)
//     mode_o        : {6'b0, tone} to the buzzer
//     busy_o        : high while a pattern plays
//     done_o        : one-cycle pulse at natural pattern end
module buzzer_seq
    import buzzer_seq_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int NSTEP    = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  mode_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int IDX_W = $clog2(NSTEP);

    step_t             steps [NSTEP];
    logic              loop_q;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              done_d;
    logic              sticky_q, sticky_d;

    logic              tick, pre_clr, pre_en;
    logic              ctrl_wr, status_rd, start, stop;
    logic [3:0]        step_off;
    logic              step_hit;
    logic [IDX_W-1:0]  step_sel;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    assign unused_wdata = ^{wdata[31:16], wdata[7:3]};

    // ---------------- bus decode ----------------
    assign ctrl_wr   = we && (addr == REG_CTRL);
    assign status_rd = re && (addr == REG_STATUS);
    assign start     = ctrl_wr && wdata[CTRL_START];
    assign stop      = ctrl_wr && wdata[CTRL_STOP];

    assign step_off  = addr - REG_STEP_BASE;
    assign step_hit  = (addr >= REG_STEP_BASE) && ({28'b0, step_off} < 32'(NSTEP));
    assign step_sel  = step_off[IDX_W-1:0];

    // ---------------- register file ----------------
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < NSTEP; i++) steps[i] <= '0;
            loop_q <= 1'b0;
        end else if (we) begin
            if (addr == REG_CTRL) loop_q <= wdata[CTRL_LOOP];
            if (step_hit) begin
                steps[step_sel].tone <= wdata[TONE_LSB +: TONE_W];
                steps[step_sel].dur  <= wdata[DUR_LSB +: DUR_W];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (addr == REG_STATUS) begin
            rd_val[STATUS_BUSY]              = busy_o;
            rd_val[STATUS_IDX_LSB +: IDX_W]  = idx_q;
            // A done event in the read cycle is reported, not lost.
            rd_val[STATUS_DONE]              = sticky_q | done_d;
        end else if (step_hit) begin
            rd_val[TONE_LSB +: TONE_W] = steps[step_sel].tone;
            rd_val[DUR_LSB +: DUR_W]   = steps[step_sel].dur;
        end
    end

    // Clear-on-read wins over a simultaneous done event; the read
    // itself already returned that event.
    assign sticky_d = status_rd ? 1'b0 : (sticky_q | done_d);

    always_ff @(posedge clk) begin
        if (RST) begin
            rdata    <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (re) rdata <= rd_val;
            sticky_q <= sticky_d;
        end
    end

    // ---------------- prescaler ----------------
    // Held at zero while idle and restarted on every START so step 0
    // always gets a full first tick period.
    assign pre_en  = (state_q == PLAY);
    assign pre_clr = start || (state_q == IDLE);

    buzzer_seq_tick #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .RST  (RST),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (tick)
    );

    // ---------------- FSM ----------------
    assign idx_nxt = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tone_q  <= '0;
            dur_q   <= '0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            done_o  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tone_d  = tone_q;
        dur_d   = dur_q;
        done_d  = 1'b0;
        mode_o  = '0;
        busy_o  = 1'b0;

        if (state_q == PLAY) begin
            mode_o[TONE_W-1:0] = tone_q;
            busy_o             = 1'b1;
        end

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            if (steps[0].dur != '0) begin
                state_d = PLAY;
                idx_d   = '0;
                tone_d  = steps[0].tone;
                dur_d   = steps[0].dur;
            end else begin
                // Empty pattern: finish immediately, even with LOOP set.
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if ((state_q == PLAY) && tick) begin
            if (dur_q == DUR_W'(1)) begin
                if ((idx_q != IDX_W'(NSTEP - 1)) && (steps[idx_nxt].dur != '0)) begin
                    idx_d  = idx_nxt;
                    tone_d = steps[idx_nxt].tone;
                    dur_d  = steps[idx_nxt].dur;
                end else if (loop_q && (steps[0].dur != '0)) begin
                    // Step 0 may have been zeroed while playing; never
                    // wrap onto an empty pattern.
                    idx_d  = '0;
                    tone_d = steps[0].tone;
                    dur_d  = steps[0].dur;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                dur_d = dur_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buzzer_seq.sv
module tb_buzzer_seq;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        we = 1'b0, re = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  mode_o;
    logic        busy_o, done_o;

    buzzer_seq #(.TICK_DIV(TD), .NSTEP(8)) dut (
        .clk(clk), .RST(RST), .we(we), .re(re), .addr(addr), .wdata(wdata),
        .rdata(rdata), .mode_o(mode_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Software's view of the step registers, and the copy taken at START.
    logic [7:0] sh_dur [8];
    logic [1:0] sh_tone[8];
    logic [7:0] sd [8];
    logic [1:0] st [8];
    bit         sloop;
    bit         stopped;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cycles of the pattern: leading steps with nonzero duration.
    function automatic int plen();
        int n = 0;
        int tot = 0;
        while (n < 8 && sd[n] != 0) begin
            tot += int'(sd[n]) * TD;
            n++;
        end
        return tot;
    endfunction

    // Expected outputs t cycles after the START write took effect.
    function automatic void model(input int t, output bit [7:0] m, output bit b,
                                  output bit d, output int ix);
        int tot, ph, acc;
        bit found;
        m = 0; b = 0; d = 0; ix = 0;
        if (stopped) return;
        tot = plen();
        if (tot == 0) begin
            d = (t == 0);
            return;
        end
        if (!sloop && t >= tot) begin
            d = (t == tot);
            return;
        end
        ph = t % tot;
        acc = 0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (!found && ph < acc + int'(sd[i]) * TD) begin
                m = {6'b0, st[i]}; b = 1; ix = i; found = 1;
            end
            acc += int'(sd[i]) * TD;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cyc();
        we = 1'b0;
        if (a >= 4'd8) begin
            sh_dur[a[2:0]]  = d[15:8];
            sh_tone[a[2:0]] = d[1:0];
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        re = 1'b1; addr = a;
        cyc();
        re = 1'b0;
        d = rdata;
    endtask

    task automatic start(input bit lp);
        wr(4'd0, {29'b0, lp, 1'b0, 1'b1});
        sd = sh_dur; st = sh_tone; sloop = lp; stopped = 0;
    endtask

    // Observe cycles t0..t0+h-1; at act_t do one bus action:
    // kind 1 write (a,d), 2 STATUS read checked against model, 3 STOP.
    task automatic run(input int t0, input int h, input int act_t, input int kind,
                       input logic [3:0] a, input logic [31:0] d);
        bit [7:0] m; bit b, dn; int ix; logic [31:0] r;
        for (int t = t0; t < t0 + h; t++) begin
            model(t, m, b, dn, ix);
            chk("mode", {24'b0, mode_o}, {24'b0, m});
            chk("busy", {31'b0, busy_o}, {31'b0, b});
            chk("done", {31'b0, done_o}, {31'b0, dn});
            if (t == act_t && kind == 1) wr(a, d);
            else if (t == act_t && kind == 2) begin
                rd(4'd1, r);
                chk("status_play", r, {23'b0, 1'b0, 1'b0, ix[2:0], 3'b0, b});
            end else if (t == act_t && kind == 3) begin
                wr(4'd0, 32'h2);
                stopped = 1;
            end else cyc();
        end
    endtask

    task automatic sticky_check(input bit exp);
        logic [31:0] r;
        rd(4'd1, r);
        chk("sticky_first", r & 32'h101, {23'b0, exp, 8'b0});
        rd(4'd1, r);
        chk("sticky_second", r & 32'h101, 32'h0);
    endtask

    initial begin
        logic [31:0] r, d;
        int tot, h, kind, act_t, k;
        bit lp, exp_done;
        for (int i = 0; i < 8; i++) begin sh_dur[i] = 0; sh_tone[i] = 0; end
        sd = sh_dur; st = sh_tone; sloop = 0; stopped = 1;

        // Reset state
        repeat (3) cyc();
        RST = 1'b0;
        chk("rst_mode", {24'b0, mode_o}, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rd(4'd1, r); chk("rst_status", r, 32'h0);
        rd(4'd8, r); chk("rst_step0", r, 32'h0);

        // Basic pattern: tone1 x2, tone3 x1, end
        wr(4'd8, 32'h0201); wr(4'd9, 32'h0103); wr(4'd10, 32'h0);
        rd(4'd9, r); chk("step1_rb", r, 32'h0103);
        rd(4'd0, r); chk("ctrl_rd_zero", r, 32'h0);
        wr(4'd3, 32'hFFFF_FFFF);
        rd(4'd3, r); chk("unmapped_rd", r, 32'h0);
        start(0);
        run(0, 16, -1, 0, 4'd0, 32'h0);
        sticky_check(1);

        // Loop over eight one-tick steps
        for (int i = 0; i < 8; i++) wr(4'(8 + i), {16'h0, 8'd1, 6'b0, 2'(i)});
        start(1);
        run(0, 70, -1, 0, 4'd0, 32'h0);
        wr(4'd0, 32'h2);
        sticky_check(0);

        // STOP after 5 cycles, then START|STOP from idle
        start(0);
        run(0, 10, 5, 3, 4'd0, 32'h0);
        wr(4'd0, 32'h3);
        stopped = 1;
        run(0, 4, -1, 0, 4'd0, 32'h0);
        sticky_check(0);

        // Empty pattern with LOOP set
        wr(4'd8, 32'h0);
        start(1);
        run(0, 40, -1, 0, 4'd0, 32'h0);
        sticky_check(1);

        // Rewrite the playing step, then restart mid step 1
        wr(4'd8, 32'h0301); wr(4'd9, 32'h0202); wr(4'd10, 32'h0);
        start(0);
        run(0, 14, 4, 1, 4'd8, 32'h0A03);
        start(0);
        run(0, 52, -1, 0, 4'd0, 32'h0);
        sticky_check(1);

        // Maximum duration
        wr(4'd8, 32'hFF02); wr(4'd9, 32'h0);
        start(0);
        run(0, 1024, -1, 0, 4'd0, 32'h0);
        sticky_check(1);

        // Randomized patterns
        for (int rnd = 0; rnd < 40; rnd++) begin
            rd(4'd1, r);
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                d[15:8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
                wr(4'(8 + i), d);
            end
            k = $urandom_range(0, 7);
            rd(4'(8 + k), r);
            chk("step_rb", r, {16'h0, sh_dur[k], 6'b0, sh_tone[k]});
            lp = 1'($urandom_range(0, 1));
            start(lp);
            tot = plen();
            h = (tot == 0) ? 4 : (lp ? 2 * tot + 6 : tot + 4);
            kind = $urandom_range(0, 2);
            act_t = -1;
            if (kind == 1) begin kind = 3; act_t = $urandom_range(0, h - 1); end
            else if (kind == 2 && tot > 0) act_t = $urandom_range(0, tot - 1);
            else kind = 0;
            run(0, h, act_t, kind, 4'd0, 32'h0);
            exp_done = (tot == 0 || !lp) && !(kind == 3 && act_t < tot);
            wr(4'd0, 32'h2);
            stopped = 1;
            sticky_check(exp_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
